// File: rtl/tlb_core.sv
// Fully associative TLB: two combinational search ports, one write port,
// one combinational read port and a free-running replacement index.
`timescale 1ns/1ps
module tlb_core #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [18:0] s0_vpn2,
    input  logic        s0_odd_page,
    input  logic [7:0]  s0_asid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_pfn,
    output logic [2:0]  s0_c,
    output logic        s0_d,
    output logic        s0_v,

    input  logic [18:0] s1_vpn2,
    input  logic        s1_odd_page,
    input  logic [7:0]  s1_asid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_pfn,
    output logic [2:0]  s1_c,
    output logic        s1_d,
    output logic        s1_v,

    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic [18:0] w_vpn2,
    input  logic [7:0]  w_asid,
    input  logic        w_g,
    input  logic [19:0] w_pfn0,
    input  logic [2:0]  w_c0,
    input  logic        w_d0,
    input  logic        w_v0,
    input  logic [19:0] w_pfn1,
    input  logic [2:0]  w_c1,
    input  logic        w_d1,
    input  logic        w_v1,

    input  logic [3:0]  r_index,
    output logic [18:0] r_vpn2,
    output logic [7:0]  r_asid,
    output logic        r_g,
    output logic [19:0] r_pfn0,
    output logic [2:0]  r_c0,
    output logic        r_d0,
    output logic        r_v0,
    output logic [19:0] r_pfn1,
    output logic [2:0]  r_c1,
    output logic        r_d1,
    output logic        r_v1,

    output logic [3:0]  random
);

    logic [18:0] vpn2_q [TLBNUM];
    logic [7:0]  asid_q [TLBNUM];
    logic        g_q    [TLBNUM];
    logic [19:0] pfn0_q [TLBNUM];
    logic [2:0]  c0_q   [TLBNUM];
    logic        d0_q   [TLBNUM];
    logic        v0_q   [TLBNUM];
    logic [19:0] pfn1_q [TLBNUM];
    logic [2:0]  c1_q   [TLBNUM];
    logic        d1_q   [TLBNUM];
    logic        v1_q   [TLBNUM];

    logic [3:0]        random_q;
    logic [3:0]        random_d;
    logic [TLBNUM-1:0] hit0_s;
    logic [TLBNUM-1:0] hit1_s;
    logic [4:0]        sel0_s;
    logic [4:0]        sel1_s;

    // Lowest-numbered set bit wins; result is {found, index}.
    function automatic logic [4:0] first_hit(input logic [TLBNUM-1:0] hv);
        logic [4:0] res;
        res = 5'd0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hv[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

    // Entry storage; a write asserted during reset is lost because reset dominates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= 19'd0;
                asid_q[i] <= 8'd0;
                g_q[i]    <= 1'b0;
                pfn0_q[i] <= 20'd0;
                c0_q[i]   <= 3'd0;
                d0_q[i]   <= 1'b0;
                v0_q[i]   <= 1'b0;
                pfn1_q[i] <= 20'd0;
                c1_q[i]   <= 3'd0;
                d1_q[i]   <= 1'b0;
                v1_q[i]   <= 1'b0;
            end
        end else if (we) begin
            vpn2_q[w_index] <= w_vpn2;
            asid_q[w_index] <= w_asid;
            g_q[w_index]    <= w_g;
            pfn0_q[w_index] <= w_pfn0;
            c0_q[w_index]   <= w_c0;
            d0_q[w_index]   <= w_d0;
            v0_q[w_index]   <= w_v0;
            pfn1_q[w_index] <= w_pfn1;
            c1_q[w_index]   <= w_c1;
            d1_q[w_index]   <= w_d1;
            v1_q[w_index]   <= w_v1;
        end
    end

    // Replacement index next state: count down and wrap to the top entry.
    always_comb begin
        random_d = random_q;
        if (random_q == 4'd0) begin
            random_d = 4'(TLBNUM - 1);
        end else begin
            random_d = random_q - 4'd1;
        end
    end

    // Replacement index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_q <= 4'(TLBNUM - 1);
        end else begin
            random_q <= random_d;
        end
    end

    // Per-entry tag match for both search ports.
    always_comb begin
        hit0_s = '0;
        hit1_s = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            hit0_s[i] = (vpn2_q[i] == s0_vpn2) && (g_q[i] || (asid_q[i] == s0_asid));
            hit1_s[i] = (vpn2_q[i] == s1_vpn2) && (g_q[i] || (asid_q[i] == s1_asid));
        end
    end

    assign sel0_s   = first_hit(hit0_s);
    assign sel1_s   = first_hit(hit1_s);
    assign s0_found = sel0_s[4];
    assign s0_index = sel0_s[3:0];
    assign s1_found = sel1_s[4];
    assign s1_index = sel1_s[3:0];

    // Search-0 page field select; all zero on a miss.
    always_comb begin
        s0_pfn = 20'd0;
        s0_c   = 3'd0;
        s0_d   = 1'b0;
        s0_v   = 1'b0;
        if (sel0_s[4]) begin
            if (s0_odd_page) begin
                s0_pfn = pfn1_q[sel0_s[3:0]];
                s0_c   = c1_q[sel0_s[3:0]];
                s0_d   = d1_q[sel0_s[3:0]];
                s0_v   = v1_q[sel0_s[3:0]];
            end else begin
                s0_pfn = pfn0_q[sel0_s[3:0]];
                s0_c   = c0_q[sel0_s[3:0]];
                s0_d   = d0_q[sel0_s[3:0]];
                s0_v   = v0_q[sel0_s[3:0]];
            end
        end else begin
            s0_pfn = 20'd0;
            s0_c   = 3'd0;
            s0_d   = 1'b0;
            s0_v   = 1'b0;
        end
    end

    // Search-1 page field select; all zero on a miss.
    always_comb begin
        s1_pfn = 20'd0;
        s1_c   = 3'd0;
        s1_d   = 1'b0;
        s1_v   = 1'b0;
        if (sel1_s[4]) begin
            if (s1_odd_page) begin
                s1_pfn = pfn1_q[sel1_s[3:0]];
                s1_c   = c1_q[sel1_s[3:0]];
                s1_d   = d1_q[sel1_s[3:0]];
                s1_v   = v1_q[sel1_s[3:0]];
            end else begin
                s1_pfn = pfn0_q[sel1_s[3:0]];
                s1_c   = c0_q[sel1_s[3:0]];
                s1_d   = d0_q[sel1_s[3:0]];
                s1_v   = v0_q[sel1_s[3:0]];
            end
        end else begin
            s1_pfn = 20'd0;
            s1_c   = 3'd0;
            s1_d   = 1'b0;
            s1_v   = 1'b0;
        end
    end

    assign r_vpn2 = vpn2_q[r_index];
    assign r_asid = asid_q[r_index];
    assign r_g    = g_q[r_index];
    assign r_pfn0 = pfn0_q[r_index];
    assign r_c0   = c0_q[r_index];
    assign r_d0   = d0_q[r_index];
    assign r_v0   = v0_q[r_index];
    assign r_pfn1 = pfn1_q[r_index];
    assign r_c1   = c1_q[r_index];
    assign r_d1   = d1_q[r_index];
    assign r_v1   = v1_q[r_index];
    assign random = random_q;

endmodule

// File: tb/tb_tlb_core.sv
// Directed self-checking bench for tlb_core: search, write/read ordering,
// replacement counter and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_tlb_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] s0_vpn2 = 19'd0, s1_vpn2 = 19'd0;
    logic        s0_odd_page = 1'b0, s1_odd_page = 1'b0;
    logic [7:0]  s0_asid = 8'd0, s1_asid = 8'd0;
    logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        we = 1'b0;
    logic [3:0]  w_index = 4'd0;
    logic [18:0] w_vpn2 = 19'd0;
    logic [7:0]  w_asid = 8'd0;
    logic        w_g = 1'b0;
    logic [19:0] w_pfn0 = 20'd0, w_pfn1 = 20'd0;
    logic [2:0]  w_c0 = 3'd0, w_c1 = 3'd0;
    logic        w_d0 = 1'b0, w_v0 = 1'b0, w_d1 = 1'b0, w_v1 = 1'b0;
    logic [3:0]  r_index = 4'd0;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g, r_d0, r_v0, r_d1, r_v1;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic [3:0]  random;

    int checks = 0;
    int failures = 0;

    tlb_core #(.TLBNUM(16)) dut (
        .clk(clk), .rst(rst),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .random(random)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic g, input logic [19:0] p0, input logic [2:0] c0, input logic d0,
                         input logic v0, input logic [19:0] p1, input logic [2:0] c1, input logic d1,
                         input logic v1);
        w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = p0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = p1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    // Single write cycle; returns at posedge+1 with the new data visible.
    task automatic do_write();
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic search(input logic [18:0] v0, input logic [7:0] a0, input logic o0,
                          input logic [18:0] v1, input logic [7:0] a1, input logic o1);
        s0_vpn2 = v0; s0_asid = a0; s0_odd_page = o0;
        s1_vpn2 = v1; s1_asid = a1; s1_odd_page = o1;
        #1;
    endtask

    initial begin
        logic [3:0] exp_rand;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_random", 32'(random), 32'd15);
        search(19'd0, 8'd0, 1'b0, 19'd1, 8'd0, 1'b0);
        chk("rst_s0_found_zero_tag", 32'(s0_found), 32'd1);
        chk("rst_s0_index", 32'(s0_index), 32'd0);
        chk("rst_s0_v", 32'(s0_v), 32'd0);
        chk("rst_s1_miss", 32'(s1_found), 32'd0);
        search(19'd0, 8'h05, 1'b0, 19'd0, 8'd0, 1'b1);
        chk("rst_s0_asid_miss", 32'(s0_found), 32'd0);

        // Write attempted during reset is discarded
        set_w(4'd1, 19'h00007, 8'h01, 1'b1, 20'h12345, 3'd1, 1'b1, 1'b1, 20'h6789A, 3'd2, 1'b1, 1'b1);
        do_write();
        r_index = 4'd1;
        #1;
        chk("rst_write_vpn2", 32'(r_vpn2), 32'd0);
        chk("rst_write_v0", 32'(r_v0), 32'd0);
        chk("rst_random_held", 32'(random), 32'd15);

        // Release between edges, then count down with writes interleaved
        @(negedge clk);
        rst = 1'b1;
        set_w(4'd9, 19'h00009, 8'h09, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("rand_k0", 32'(random), 32'd15);
        for (int k = 1; k <= 16; k++) begin
            we = (k % 2 == 1) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            exp_rand = 4'd15 - 4'(k);
            chk($sformatf("rand_k%0d", k), 32'(random), 32'(exp_rand));
        end
        we = 1'b0;

        // Entry 3 with distinct even/odd page fields
        set_w(4'd3, 19'h12345, 8'h05, 1'b0, 20'h00ABC, 3'd2, 1'b1, 1'b1, 20'h00DEF, 3'd5, 1'b0, 1'b1);
        do_write();
        search(19'h12345, 8'h05, 1'b1, 19'h12345, 8'h05, 1'b0);
        chk("e3_odd_found", 32'(s0_found), 32'd1);
        chk("e3_odd_index", 32'(s0_index), 32'd3);
        chk("e3_odd_pfn", 32'(s0_pfn), 32'h00DEF);
        chk("e3_odd_c", 32'(s0_c), 32'd5);
        chk("e3_odd_d", 32'(s0_d), 32'd0);
        chk("e3_odd_v", 32'(s0_v), 32'd1);
        chk("e3_even_pfn", 32'(s1_pfn), 32'h00ABC);
        chk("e3_even_c", 32'(s1_c), 32'd2);
        chk("e3_even_d", 32'(s1_d), 32'd1);

        // ASID mismatch misses with zeroed outputs; global bit then overrides
        search(19'h12345, 8'h06, 1'b1, 19'h12345, 8'h06, 1'b0);
        chk("asid_miss_found", 32'(s0_found), 32'd0);
        chk("asid_miss_index", 32'(s0_index), 32'd0);
        chk("asid_miss_pfn", 32'(s0_pfn), 32'd0);
        chk("asid_miss_cdv", 32'({s0_c, s0_d, s0_v}), 32'd0);
        set_w(4'd3, 19'h12345, 8'h05, 1'b1, 20'h00ABC, 3'd2, 1'b1, 1'b1, 20'h00DEF, 3'd5, 1'b0, 1'b1);
        do_write();
        #1;
        chk("g_hit_found", 32'(s0_found), 32'd1);
        chk("g_hit_index", 32'(s0_index), 32'd3);
        r_index = 4'd3;
        #1;
        chk("read3_asid", 32'(r_asid), 32'h05);
        chk("read3_g", 32'(r_g), 32'd1);
        chk("read3_page1", 32'({r_pfn1, r_c1, r_d1, r_v1}), 32'({20'h00DEF, 3'd5, 1'b0, 1'b1}));
        chk("read3_page0", 32'({r_pfn0, r_c0, r_d0, r_v0}), 32'({20'h00ABC, 3'd2, 1'b1, 1'b1}));

        // Duplicate global entries: lowest index wins on both ports
        set_w(4'd7, 19'h00400, 8'h02, 1'b1, 20'h07000, 3'd0, 1'b0, 1'b1, 20'h07001, 3'd0, 1'b0, 1'b1);
        do_write();
        set_w(4'd2, 19'h00400, 8'h01, 1'b1, 20'h02000, 3'd0, 1'b0, 1'b1, 20'h02001, 3'd0, 1'b0, 1'b1);
        do_write();
        search(19'h00400, 8'h33, 1'b0, 19'h00400, 8'h33, 1'b1);
        chk("dup_s0_index", 32'(s0_index), 32'd2);
        chk("dup_s1_index", 32'(s1_index), 32'd2);
        chk("dup_s0_pfn", 32'(s0_pfn), 32'h02000);
        chk("dup_s1_pfn", 32'(s1_pfn), 32'h02001);
        search(19'h12345, 8'h06, 1'b0, 19'h00400, 8'h07, 1'b0);
        chk("indep_s0_index", 32'(s0_index), 32'd3);
        chk("indep_s0_pfn", 32'(s0_pfn), 32'h00ABC);
        chk("indep_s1_index", 32'(s1_index), 32'd2);

        // Write/read collision on entry 5: old data this cycle, new data next
        set_w(4'd5, 19'h00555, 8'h10, 1'b0, 20'h11111, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        do_write();
        set_w(4'd5, 19'h00AAA, 8'h10, 1'b0, 20'h22222, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        we = 1'b1;
        r_index = 4'd5;
        search(19'h00555, 8'h10, 1'b0, 19'h00AAA, 8'h10, 1'b0);
        chk("coll_old_read", 32'(r_vpn2), 32'h00555);
        chk("coll_old_s0_pfn", 32'(s0_pfn), 32'h11111);
        chk("coll_new_s1_miss", 32'(s1_found), 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        chk("coll_new_read", 32'(r_vpn2), 32'h00AAA);
        chk("coll_old_gone", 32'(s0_found), 32'd0);
        chk("coll_new_s1_index", 32'(s1_index), 32'd5);
        chk("coll_new_s1_pfn", 32'(s1_pfn), 32'h22222);

        // Asynchronous reset mid-run clears state before any clock edge
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_random", 32'(random), 32'd15);
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #0.1;
            chk($sformatf("async_v_idx%0d", i), 32'({r_v0, r_v1}), 32'd0);
        end
        r_index = 4'd3;
        #0.1;
        chk("async_vpn2_idx3", 32'(r_vpn2), 32'd0);
        @(posedge clk);
        #1;
        chk("async_random_held", 32'(random), 32'd15);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release_first_dec", 32'(random), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
